// File: rtl/rr_sel_arbiter_pkg.sv
// rr_sel_arbiter_pkg
// Shared definitions for the 4-channel round-robin select arbiter:
// FSM state encoding, channel count, select width, the default grant-length
// limit, and a one-hot decode helper.
package rr_sel_arbiter_pkg;

   localparam int unsigned NUM_CH             = 4;
   localparam int unsigned SEL_W              = 2;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] i);
      return NUM_CH'(1) << i;
   endfunction

endpackage

// File: rtl/rr_sel_arbiter_4_pick.sv
// rr_pick_4
// Combinational rotating-priority search over four request lines.
// Ports:
//   req  [3:0] in  - raw request vector
//   ptr  [1:0] in  - channel searched first; order is ptr, ptr+1, ptr+2, ptr+3 (mod 4)
//   mask [3:0] in  - channels excluded from this search
//   any        out - at least one unmasked request present
//   idx  [1:0] out - winning channel (equals ptr when any=0)
module rr_pick_4
   import rr_sel_arbiter_pkg::*;
(
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   input  logic [NUM_CH-1:0] mask,
   output logic              any,
   output logic [SEL_W-1:0]  idx
);

   logic [NUM_CH-1:0] cand;

   assign cand = req & ~mask;

   always_comb begin
      logic [SEL_W-1:0] c;
      c   = '0;
      any = 1'b0;
      idx = ptr;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         // 2-bit add wraps naturally, giving the mod-4 search order
         c = ptr + SEL_W'(k);
         if (!any && cand[c]) begin
            any = 1'b1;
            idx = c;
         end
      end
   end

endmodule

// File: rtl/rr_sel_arbiter_4.sv
// rr_sel_arbiter_4
// Round-robin arbiter driving the select of a downstream 4:1 mux.
// A grant is held until done=1, the holder drops its request, or (optionally)
// the grant-length limit is reached; the next requester is granted on the same
// edge, never re-granting the channel that just released.
// Ports:
//   clk          in  - clock, rising edge
//   rst          in  - asynchronous active-high reset
//   req   [3:0]  in  - per-channel requests
//   done         in  - holder's last cycle (ignored when idle)
//   sel   [1:0]  out - mux select, holds its value while idle
//   grant [3:0]  out - one-hot of sel while valid, else 0
//   valid        out - a grant is held
//   timeout      out - one-cycle pulse on a forced release
// Configuration:
//   RR_SEL_ARBITER_TIMEOUT_EN - when defined, grants are limited to
//   TIMEOUT_CYCLES cycles (legal range 2..255); otherwise grants are unbounded
//   and timeout is tied to 0.
module rr_sel_arbiter_4
   import rr_sel_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] req,
   input  logic              done,
   output logic [SEL_W-1:0]  sel,
   output logic [NUM_CH-1:0] grant,
   output logic              valid,
   output logic              timeout
);

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 2..255");
   end

   state_t            state_q, state_d;
   logic [SEL_W-1:0]  ptr_q, ptr_d;
   logic [SEL_W-1:0]  sel_d;
   logic [NUM_CH-1:0] grant_d;
   logic              valid_d;
   logic              timeout_d;

   logic [SEL_W-1:0]  next_ptr;
   logic [SEL_W-1:0]  pick_ptr;
   logic [NUM_CH-1:0] pick_mask;
   logic              pick_any;
   logic [SEL_W-1:0]  pick_idx;
   logic              expire;
   logic              release_now;
   logic              forced;

   // One shared search: in GRANT it looks ahead from the post-release pointer
   // with the holder masked, so a back-to-back grant needs no extra cycle.
   assign next_ptr  = sel + 1'b1;
   assign pick_ptr  = (state_q == GRANT) ? next_ptr : ptr_q;
   assign pick_mask = (state_q == GRANT) ? onehot(sel) : '0;

   rr_pick_4 u_pick (
      .req  (req),
      .ptr  (pick_ptr),
      .mask (pick_mask),
      .any  (pick_any),
      .idx  (pick_idx)
   );

`ifdef RR_SEL_ARBITER_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;

   assign expire = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = '0;
      if (state_q == GRANT && !release_now) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign expire = 1'b0;
`endif

   assign release_now = done | ~req[sel] | expire;
   // A limit hit coinciding with a normal release is reported as normal
   assign forced      = expire & ~done & req[sel];

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      sel_d     = sel;
      grant_d   = grant;
      valid_d   = valid;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d = GRANT;
               sel_d   = pick_idx;
               grant_d = onehot(pick_idx);
               valid_d = 1'b1;
            end
         end
         GRANT: begin
            if (release_now) begin
               ptr_d     = next_ptr;
               timeout_d = forced;
               if (pick_any) begin
                  sel_d   = pick_idx;
                  grant_d = onehot(pick_idx);
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
                  valid_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         sel     <= '0;
         grant   <= '0;
         valid   <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel     <= sel_d;
         grant   <= grant_d;
         valid   <= valid_d;
         timeout <= timeout_d;
      end
   end

endmodule

// File: tb/tb_rr_sel_arbiter_4.sv
// tb_rr_sel_arbiter_4
// Scoreboard bench for rr_sel_arbiter_4. A driver applies directed and random
// req/done patterns, advances a reference model written from the arbitration
// rules, and queues the expected outputs; a monitor compares them each cycle.
// Honours RR_SEL_ARBITER_TIMEOUT_EN (uses TIMEOUT_CYCLES=4 when defined).
module tb_rr_sel_arbiter_4;

`ifdef RR_SEL_ARBITER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
   localparam int TO    = 4;
`else
   localparam bit TO_EN = 1'b0;
   localparam int TO    = 16;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = '0;
   logic       done = 1'b0;
   logic [1:0] sel;
   logic [3:0] grant;
   logic       valid;
   logic       timeout;

   typedef struct {
      logic [1:0] sel;
      logic [3:0] grant;
      logic       valid;
      logic       timeout;
   } exp_t;

   exp_t exp_q[$];

   int vectors     = 0;
   int miscompares = 0;

   // reference model state
   int m_ptr  = 0;
   int m_sel  = 0;
   bit m_hold = 0;
   int m_cnt  = 0;

   rr_sel_arbiter_4 #(.TIMEOUT_CYCLES(TO)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .done    (done),
      .sel     (sel),
      .grant   (grant),
      .valid   (valid),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input int act, input int expv);
      vectors++;
      if (act != expv) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endfunction

   function automatic int first_from(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++) begin
         int c = (p + k) % 4;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   function automatic void push_exp(input bit t);
      exp_t e;
      e.sel     = 2'(m_sel);
      e.valid   = m_hold;
      e.grant   = m_hold ? (4'b0001 << m_sel) : 4'b0000;
      e.timeout = t;
      exp_q.push_back(e);
   endfunction

   function automatic void model_step(input logic [3:0] r, input logic d);
      bit t = 0;
      if (!m_hold) begin
         if (r != 4'b0000) begin
            m_sel  = first_from(r, m_ptr);
            m_hold = 1;
            m_cnt  = 0;
         end
      end else begin
         bit forced = TO_EN && (m_cnt == TO - 1);
         if (d || !r[m_sel] || forced) begin
            logic [3:0] others;
            t      = forced && !d && r[m_sel];
            m_ptr  = (m_sel + 1) % 4;
            m_cnt  = 0;
            others = r & ~(4'b0001 << m_sel);
            if (others != 4'b0000) m_sel = first_from(others, m_ptr);
            else m_hold = 0;
         end else begin
            m_cnt++;
         end
      end
      push_exp(t);
   endfunction

   // called at a negedge, returns at the next negedge
   task automatic cyc(input logic [3:0] r, input logic d);
      req  = r;
      done = d;
      @(posedge clk);
      model_step(r, d);
      @(negedge clk);
   endtask

   // asserts reset away from any edge and checks it acts immediately
   task automatic do_reset();
      req  = '0;
      done = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_valid",   int'(valid),   0);
      chk("rst_grant",   int'(grant),   0);
      chk("rst_sel",     int'(sel),     0);
      chk("rst_timeout", int'(timeout), 0);
      m_ptr = 0; m_sel = 0; m_hold = 0; m_cnt = 0;
      @(posedge clk);
      push_exp(0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // monitor / scoreboard
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (sel !== e.sel || grant !== e.grant || valid !== e.valid || timeout !== e.timeout) begin
               miscompares++;
               $display("FAIL scoreboard @%0t: got sel=%0d grant=%b valid=%b timeout=%b, expected sel=%0d grant=%b valid=%b timeout=%b",
                        $time, sel, grant, valid, timeout, e.sel, e.grant, e.valid, e.timeout);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int exp_seq[5];
      logic [3:0] r;
      exp_seq = '{0, 1, 2, 3, 0};

      @(negedge clk);
      do_reset();

      // single request, one-cycle latency
      cyc(4'b0100, 1'b0);
      chk("first_sel",   int'(sel),   2);
      chk("first_grant", int'(grant), 4);
      chk("first_valid", int'(valid), 1);
      // holder drops req with nobody else requesting
      cyc(4'b0000, 1'b0);
      chk("drop_idle_valid", int'(valid), 0);
      chk("drop_idle_grant", int'(grant), 0);
      chk("drop_idle_sel",   int'(sel),   2);

      // full rotation, back-to-back
      do_reset();
      cyc(4'b1111, 1'b0);
      chk("rot_sel_0", int'(sel), exp_seq[0]);
      for (int i = 1; i < 5; i++) begin
         cyc(4'b1111, 1'b1);
         chk($sformatf("rot_sel_%0d", i), int'(sel), exp_seq[i]);
         chk($sformatf("rot_valid_%0d", i), int'(valid), 1);
      end

      // pointer advance after release to idle
      do_reset();
      cyc(4'b0010, 1'b0);
      chk("ptr_hold_sel", int'(sel), 1);
      cyc(4'b0010, 1'b1);
      chk("ptr_rel_valid", int'(valid), 0);
      cyc(4'b0011, 1'b0);
      chk("ptr_next_sel", int'(sel), 0);
      cyc(4'b0011, 1'b1);
      chk("no_regrant_sel", int'(sel), 1);

      // grant-length limit
      if (TO_EN) begin
         do_reset();
         for (int i = 0; i < 4; i++) begin
            cyc(4'b0011, 1'b0);
            chk($sformatf("to_hold_%0d", i), int'(sel), 0);
            chk($sformatf("to_quiet_%0d", i), int'(timeout), 0);
         end
         cyc(4'b0011, 1'b0);
         chk("to_next_sel", int'(sel), 1);
         chk("to_pulse", int'(timeout), 1);
         cyc(4'b0011, 1'b0);
         chk("to_pulse_end", int'(timeout), 0);
      end

      // reset in the middle of a grant
      do_reset();
      cyc(4'b1000, 1'b0);
      chk("mid_sel", int'(sel), 3);
      cyc(4'b1000, 1'b0);
      do_reset();
      cyc(4'b1000, 1'b0);
      chk("after_rst_sel",   int'(sel),   3);
      chk("after_rst_valid", int'(valid), 1);

      // random traffic
      r = 4'($urandom_range(0, 15));
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 63) == 0) do_reset();
         cyc(r, ($urandom_range(0, 3) == 0));
      end

      cyc(4'b0000, 1'b0);
      cyc(4'b0000, 1'b0);
      chk("queue_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
